// File: rtl/coin_start_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : coin_start_conditioner
//  Description : Conditions raw coin and start buttons for the pacman core.
//                Each coin channel is synchronized, debounced, turned into a
//                fixed-length pulse, held off until the key is released and
//                then locked out. Start buttons are synchronized and debounced
//                as plain levels. A saturating counter tallies accepted coins.
//  Ports       : clk        - system clock (clk_sys domain)
//                reset      - synchronous, active-high reset
//                ce         - timing tick; all timers advance only when high
//                coin_in    - raw coin buttons, active-high
//                start_in   - raw start buttons [0]=1P [1]=2P, active-high
//                coin_out   - conditioned coin pulses, active-high
//                start_out  - debounced start levels, active-high
//                busy       - channel FSM not idle
//                coin_count - saturating count of accepted coins
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_start_conditioner #(
    parameter int N_COIN    = 2,
    parameter int CNT_W     = 20,
    parameter int DEB_LEN   = 6000,
    parameter int PULSE_LEN = 120000,
    parameter int LOCK_LEN  = 60000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [N_COIN-1:0] coin_in,
    input  logic [1:0]        start_in,
    output logic [N_COIN-1:0] coin_out,
    output logic [1:0]        start_out,
    output logic [N_COIN-1:0] busy,
    output logic [7:0]        coin_count
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_debounce = 3'd1;
    localparam logic [2:0] c_st_pulse    = 3'd2;
    localparam logic [2:0] c_st_wait_rel = 3'd3;
    localparam logic [2:0] c_st_lockout  = 3'd4;

    // Timers count down from LEN-1 so that a timed state spans LEN ticks.
    localparam logic [CNT_W-1:0] c_deb_load   = CNT_W'(DEB_LEN - 1);
    localparam logic [CNT_W-1:0] c_pulse_load = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] c_lock_load  = CNT_W'(LOCK_LEN - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers for every raw input.
    // ------------------------------------------------------------------
    logic [N_COIN-1:0] r_coin_m;
    logic [N_COIN-1:0] r_coin_s;
    logic [1:0]        r_start_m;
    logic [1:0]        r_start_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_m  <= '0;
            r_coin_s  <= '0;
            r_start_m <= '0;
            r_start_s <= '0;
        end else begin
            r_coin_m  <= coin_in;
            r_coin_s  <= r_coin_m;
            r_start_m <= start_in;
            r_start_s <= r_start_m;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel coin FSM.
    // ------------------------------------------------------------------
    logic [N_COIN-1:0] w_accept;

    for (genvar g = 0; g < N_COIN; g++) begin : g_coin
        logic [2:0]       r_state;
        logic [2:0]       w_state_nxt;
        logic [CNT_W-1:0] r_timer;
        logic [CNT_W-1:0] w_timer_nxt;
        logic             w_tmr_zero;
        logic             w_acc;
        logic             r_coin_out;
        logic             r_busy;

        assign w_tmr_zero = (r_timer == '0);

        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_acc       = 1'b0;
            if (ce) begin
                case (r_state)
                    c_st_idle: begin
                        if (r_coin_s[g]) begin
                            w_state_nxt = c_st_debounce;
                            w_timer_nxt = c_deb_load;
                        end
                    end
                    c_st_debounce: begin
                        if (!r_coin_s[g]) begin
                            w_state_nxt = c_st_idle;
                            w_timer_nxt = '0;
                        end else if (w_tmr_zero) begin
                            w_state_nxt = c_st_pulse;
                            w_timer_nxt = c_pulse_load;
                            w_acc       = 1'b1;
                        end else begin
                            w_timer_nxt = r_timer - c_one;
                        end
                    end
                    // The pulse ignores the key so an early release still
                    // produces a full-length credit pulse.
                    c_st_pulse: begin
                        if (w_tmr_zero) begin
                            w_state_nxt = c_st_wait_rel;
                            w_timer_nxt = c_deb_load;
                        end else begin
                            w_timer_nxt = r_timer - c_one;
                        end
                    end
                    // Any sign of the key restarts the release debounce, so a
                    // held key parks here indefinitely.
                    c_st_wait_rel: begin
                        if (r_coin_s[g]) begin
                            w_timer_nxt = c_deb_load;
                        end else if (w_tmr_zero) begin
                            w_state_nxt = c_st_lockout;
                            w_timer_nxt = c_lock_load;
                        end else begin
                            w_timer_nxt = r_timer - c_one;
                        end
                    end
                    c_st_lockout: begin
                        if (w_tmr_zero) begin
                            w_state_nxt = c_st_idle;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer - c_one;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                        w_timer_nxt = '0;
                    end
                endcase
            end
        end

        // Outputs are registered from the next state so they line up with it.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state    <= c_st_idle;
                r_timer    <= '0;
                r_coin_out <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_timer    <= w_timer_nxt;
                r_coin_out <= (w_state_nxt == c_st_pulse);
                r_busy     <= (w_state_nxt != c_st_idle);
            end
        end

        assign w_accept[g] = w_acc;
        assign coin_out[g] = r_coin_out;
        assign busy[g]     = r_busy;
    end

    // ------------------------------------------------------------------
    // Saturating credit counter; simultaneous accepts all count.
    // ------------------------------------------------------------------
    logic [7:0] r_coin_count;
    logic [7:0] w_inc;
    logic [8:0] w_sum;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < N_COIN; i++) begin
            w_inc = w_inc + 8'(w_accept[i]);
        end
        w_sum = {1'b0, r_coin_count} + {1'b0, w_inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_count <= '0;
        end else begin
            r_coin_count <= w_sum[8] ? 8'hFF : w_sum[7:0];
        end
    end

    assign coin_count = r_coin_count;

    // ------------------------------------------------------------------
    // Start button level debouncers.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_start
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (ce) begin
                if (r_start_s[g] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_load) begin
                    r_level <= r_start_s[g];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end
        end

        assign start_out[g] = r_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_start_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_start_conditioner
//  Description : Self-checking bench for coin_start_conditioner. A sequential
//                reference model predicts each coin pulse (start cycle and
//                end cycle) into a queue; an independent monitor measures the
//                pulses the DUT produces and pops the matching prediction.
//                Credit count, busy flags and start levels are compared each
//                cycle against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_start_conditioner;

    localparam int N_COIN    = 2;
    localparam int CNT_W     = 20;
    localparam int DEB_LEN   = 4;
    localparam int PULSE_LEN = 8;
    localparam int LOCK_LEN  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce = 1'b1;
    logic [N_COIN-1:0] coin_in = '0;
    logic [1:0]        start_in = '0;
    logic [N_COIN-1:0] coin_out;
    logic [1:0]        start_out;
    logic [N_COIN-1:0] busy;
    logic [7:0]        coin_count;

    coin_start_conditioner #(
        .N_COIN   (N_COIN),
        .CNT_W    (CNT_W),
        .DEB_LEN  (DEB_LEN),
        .PULSE_LEN(PULSE_LEN),
        .LOCK_LEN (LOCK_LEN)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .coin_in   (coin_in),
        .start_in  (start_in),
        .coin_out  (coin_out),
        .start_out (start_out),
        .busy      (busy),
        .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int ch;
        int st;
        int en;
    } pulse_t;

    pulse_t      exp_q[$];
    int          n_pushed = 0;
    int          m_count = 0;
    logic [1:0]  m_busy = '0;
    logic [1:0]  m_start = '0;
    int          m_sdiff[2] = '{0, 0};
    logic [1:0]  m_s1 = '0, m_s2 = '0;
    logic [1:0]  m_ss1 = '0, m_ss2 = '0;

    // Model's view of the synchronized inputs: two clocks of delay.
    always @(posedge clk) begin
        if (reset) begin
            m_s1 <= '0; m_s2 <= '0; m_ss1 <= '0; m_ss2 <= '0;
        end else begin
            m_s1 <= coin_in;  m_s2 <= m_s1;
            m_ss1 <= start_in; m_ss2 <= m_ss1;
        end
    end

    always @(posedge clk) begin
        if (reset) m_count = 0;
    end

    // Start level follows input once it has disagreed for DEB_LEN ticks.
    always @(posedge clk) begin
        if (reset) begin
            m_start = '0;
            m_sdiff = '{0, 0};
        end else if (ce) begin
            for (int b = 0; b < 2; b++) begin
                if (m_ss2[b] != m_start[b]) begin
                    m_sdiff[b]++;
                    if (m_sdiff[b] == DEB_LEN) begin
                        m_start[b] = m_ss2[b];
                        m_sdiff[b] = 0;
                    end
                end else begin
                    m_sdiff[b] = 0;
                end
            end
        end
    end

    // Returns at the next ce tick, or at a reset edge (r=1).
    task automatic wait_tick(output bit r);
        do @(posedge clk); while (!reset && !ce);
        r = reset;
    endtask

    // A coin's life as a sequence of waits counted in ce ticks.
    task automatic coin_model(input int ch);
        bit r;
        int n;
        int st;
        forever begin
            m_busy[ch] = 1'b0;
            do wait_tick(r); while (!r && !m_s2[ch]);
            if (r) continue;
            m_busy[ch] = 1'b1;
            // need DEB_LEN further ticks with key still down
            n = 0;
            while (n < DEB_LEN) begin
                wait_tick(r);
                if (r || !m_s2[ch]) break;
                n++;
            end
            if (r || n < DEB_LEN) continue;
            m_count = (m_count >= 255) ? 255 : m_count + 1;
            st = cyc + 1;
            n = 0;
            while (n < PULSE_LEN) begin
                wait_tick(r);
                if (r) break;
                n++;
            end
            if (r) continue;
            exp_q.push_back('{ch: ch, st: st, en: cyc + 1});
            n_pushed++;
            // release must be seen on DEB_LEN consecutive ticks
            n = 0;
            while (n < DEB_LEN) begin
                wait_tick(r);
                if (r) break;
                n = m_s2[ch] ? 0 : n + 1;
            end
            if (r) continue;
            n = 0;
            while (n < LOCK_LEN) begin
                wait_tick(r);
                if (r) break;
                n++;
            end
        end
    endtask

    initial coin_model(0);
    initial coin_model(1);

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [1:0] prev_out = '0;
    int         rise_cyc[2] = '{0, 0};
    int         n_popped = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("coin_count", coin_count, m_count);
            check("busy", busy, m_busy);
            check("start_out", start_out, m_start);
            if (reset) check("coin_out_in_reset", coin_out, 0);
            for (int c = 0; c < N_COIN; c++) begin
                if (coin_out[c] && !prev_out[c]) rise_cyc[c] = cyc;
                if (!coin_out[c] && prev_out[c] && !reset) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].ch == c) begin
                            idx = i;
                            break;
                        end
                    end
                    if (idx < 0) begin
                        check("unexpected_pulse", c, -1);
                    end else begin
                        check("pulse_start", rise_cyc[c], exp_q[idx].st);
                        check("pulse_end", cyc, exp_q[idx].en);
                        exp_q.delete(idx);
                        n_popped++;
                    end
                end
            end
            prev_out = coin_out;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int ce_mode = 0;   // 0: always, 1: every 4th cycle, 2: random

    initial begin
        forever begin
            @(negedge clk);
            case (ce_mode)
                0:       ce = 1'b1;
                1:       ce = ((cyc % 4) == 0);
                default: ce = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(5);

        // single held coin
        coin_in[0] = 1'b1; step(30);
        coin_in[0] = 1'b0; step(30);
        // short bounce, rejected
        coin_in[0] = 1'b1; step(3);
        coin_in[0] = 1'b0; step(20);
        // long hold then second press
        coin_in[0] = 1'b1; step(100);
        coin_in[0] = 1'b0; step(30);
        coin_in[0] = 1'b1; step(20);
        coin_in[0] = 1'b0; step(30);
        // simultaneous coins up to saturation
        repeat (130) begin
            coin_in = 2'b11; step(16);
            coin_in = 2'b00; step(20);
        end
        check("count_saturated", coin_count, 255);

        // sparse ce
        reset = 1'b1; step(2); reset = 1'b0;
        ce_mode = 1;
        step(4);
        coin_in[1] = 1'b1; step(200);
        coin_in[1] = 1'b0; step(200);
        ce_mode = 0;
        step(4);

        // reset in the middle of a pulse
        coin_in[0] = 1'b1; step(10);
        check("pulse_live_before_reset", coin_out[0], 1);
        reset = 1'b1; step(2); reset = 1'b0;
        coin_in[0] = 1'b0; step(20);

        // start bounce then stable press
        repeat (10) begin
            start_in[1] = 1'b1; step(2);
            start_in[1] = 1'b0; step(2);
        end
        check("start_bounce_rejected", start_out[1], 0);
        start_in[1] = 1'b1; step(5);
        check("start_not_yet", start_out[1], 0);
        step(1);
        check("start_after_six", start_out[1], 1);
        step(10);
        start_in[1] = 1'b0; step(20);

        // random traffic, random and full ce
        ce_mode = 2;
        repeat (300) begin
            coin_in  = 2'($urandom);
            start_in = 2'($urandom);
            step($urandom_range(1, 12));
        end
        ce_mode = 0;
        repeat (300) begin
            coin_in  = 2'($urandom);
            start_in = 2'($urandom);
            step($urandom_range(1, 20));
        end
        coin_in = '0;
        start_in = '0;
        step(100);

        check("pending_pulses", exp_q.size(), 0);
        check("pulses_matched", n_popped, n_pushed);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
